// File: rtl/seg7_decoder_if.sv
// Bundle of the 7-segment sample bus and the decoded-value valid/ready port.
// The decoder sits on the slave modport; the consumer or driver sits on the master modport.
interface seg7_decoder_if;
    logic [6:0] seg7;
    logic [4:0] code_out;
    logic       code_err;
    logic       code_valid;
    logic       code_ready;
    logic       overrun;
    logic       overrun_clr;

    modport slave (
        input  seg7,
        input  code_ready,
        input  overrun_clr,
        output code_out,
        output code_err,
        output code_valid,
        output overrun
    );

    modport master (
        output seg7,
        output code_ready,
        output overrun_clr,
        input  code_out,
        input  code_err,
        input  code_valid,
        input  overrun
    );
endinterface

// File: rtl/seg7_decoder.sv
// Recovers the hex digit shown on an asynchronous 7-segment bus: sync, debounce, decode,
// and present it on a valid/ready port with sticky overrun detection.
module seg7_decoder #(
    parameter int STABLE_CYCLES  = 4,
    parameter int CNT_W          = 8,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    seg7_decoder_if.slave  bus
);

    typedef enum logic [0:0] {
        ST_SETTLE = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LP_ACCEPT_CNT = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LP_CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] LP_CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    // Returns {err, code[4:0]} for an active-high gfedcba pattern.
    function automatic logic [5:0] f_decode(input logic [6:0] pat);
        logic [5:0] res;
        case (pat)
            7'h3F:   res = {1'b0, 5'h00};
            7'h06:   res = {1'b0, 5'h01};
            7'h5B:   res = {1'b0, 5'h02};
            7'h4F:   res = {1'b0, 5'h03};
            7'h66:   res = {1'b0, 5'h04};
            7'h6D:   res = {1'b0, 5'h05};
            7'h7D:   res = {1'b0, 5'h06};
            7'h07:   res = {1'b0, 5'h07};
            7'h7F:   res = {1'b0, 5'h08};
            7'h6F:   res = {1'b0, 5'h09};
            7'h77:   res = {1'b0, 5'h0A};
            7'h7C:   res = {1'b0, 5'h0B};
            7'h39:   res = {1'b0, 5'h0C};
            7'h5E:   res = {1'b0, 5'h0D};
            7'h79:   res = {1'b0, 5'h0E};
            7'h71:   res = {1'b0, 5'h0F};
            7'h00:   res = {1'b0, 5'h10};
            default: res = {1'b1, 5'h1F};
        endcase
        return res;
    endfunction

    logic [6:0]       r_s1;
    logic [6:0]       r_s2;
    logic [6:0]       r_held;
    logic [6:0]       r_last_pat;
    logic [CNT_W-1:0] r_cnt;
    state_t           r_state;
    logic             r_emitted_any;
    logic [4:0]       r_code_out;
    logic             r_code_err;
    logic             r_code_valid;
    logic             r_overrun;

    logic [6:0]       w_p;
    logic [6:0]       w_held_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    state_t           w_state_nxt;
    logic             w_accept;
    logic             w_emit;
    logic [5:0]       w_dec;
    logic [4:0]       w_code_out_nxt;
    logic             w_code_err_nxt;
    logic             w_code_valid_nxt;
    logic             w_overrun_nxt;
    logic [6:0]       w_last_pat_nxt;
    logic             w_emitted_any_nxt;

    assign w_p = (SEG_ACTIVE_LOW != 0) ? ~r_s2 : r_s2;

    // Stability tracking and SETTLE/LOCKED next-state logic.
    always_comb begin
        w_held_nxt  = r_held;
        w_cnt_nxt   = r_cnt;
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        if (w_p != r_held) begin
            w_held_nxt  = w_p;
            w_cnt_nxt   = {CNT_W{1'b0}};
            w_state_nxt = ST_SETTLE;
        end else begin
            w_cnt_nxt = (r_cnt == LP_CNT_MAX) ? r_cnt : (r_cnt + LP_CNT_ONE);
            case (r_state)
                ST_SETTLE: begin
                    if (r_cnt == LP_ACCEPT_CNT) begin
                        w_accept    = 1'b1;
                        w_state_nxt = ST_LOCKED;
                    end else begin
                        w_state_nxt = ST_SETTLE;
                    end
                end
                ST_LOCKED: w_state_nxt = ST_LOCKED;
                default:   w_state_nxt = ST_SETTLE;
            endcase
        end
    end

    // Emission, valid/ready handshake and overrun next-state logic.
    always_comb begin
        w_dec             = f_decode(r_held);
        w_emit            = w_accept && (!r_emitted_any || (r_held != r_last_pat));
        w_code_out_nxt    = r_code_out;
        w_code_err_nxt    = r_code_err;
        w_code_valid_nxt  = r_code_valid;
        w_overrun_nxt     = r_overrun;
        w_last_pat_nxt    = r_last_pat;
        w_emitted_any_nxt = r_emitted_any;
        if (w_accept) begin
            w_last_pat_nxt    = r_held;
            w_emitted_any_nxt = 1'b1;
        end else begin
            w_last_pat_nxt    = r_last_pat;
        end
        if (w_emit) begin
            w_code_out_nxt   = w_dec[4:0];
            w_code_err_nxt   = w_dec[5];
            w_code_valid_nxt = 1'b1;
        end else if (r_code_valid && bus.code_ready) begin
            w_code_valid_nxt = 1'b0;
        end else begin
            w_code_valid_nxt = r_code_valid;
        end
        // Clear has priority over a same-cycle overwrite.
        if (bus.overrun_clr) begin
            w_overrun_nxt = 1'b0;
        end else if (w_emit && r_code_valid && !bus.code_ready) begin
            w_overrun_nxt = 1'b1;
        end else begin
            w_overrun_nxt = r_overrun;
        end
    end

    // State register for synchronizer, debounce FSM and output port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1          <= 7'h00;
            r_s2          <= 7'h00;
            r_held        <= 7'h00;
            r_last_pat    <= 7'h00;
            r_cnt         <= {CNT_W{1'b0}};
            r_state       <= ST_SETTLE;
            r_emitted_any <= 1'b0;
            r_code_out    <= 5'h00;
            r_code_err    <= 1'b0;
            r_code_valid  <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_s1          <= bus.seg7;
            r_s2          <= r_s1;
            r_held        <= w_held_nxt;
            r_last_pat    <= w_last_pat_nxt;
            r_cnt         <= w_cnt_nxt;
            r_state       <= w_state_nxt;
            r_emitted_any <= w_emitted_any_nxt;
            r_code_out    <= w_code_out_nxt;
            r_code_err    <= w_code_err_nxt;
            r_code_valid  <= w_code_valid_nxt;
            r_overrun     <= w_overrun_nxt;
        end
    end

    assign bus.code_out   = r_code_out;
    assign bus.code_err   = r_code_err;
    assign bus.code_valid = r_code_valid;
    assign bus.overrun    = r_overrun;

endmodule

// File: tb/tb_seg7_decoder.sv
// Directed bench for seg7_decoder: an active-high instance for most scenarios and an
// active-low instance for the inverted-bus case.
module tb_seg7_decoder;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    seg7_decoder_if bus_hi ();
    seg7_decoder_if bus_lo ();

    seg7_decoder #(.STABLE_CYCLES(4), .CNT_W(8), .SEG_ACTIVE_LOW(0)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_hi)
    );

    seg7_decoder #(.STABLE_CYCLES(4), .CNT_W(8), .SEG_ACTIVE_LOW(1)) u_dut_al (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Runs n cycles on the active-high instance, counting valid cycles and capturing the first one.
    task automatic run_window(input int n, output int pulses, output logic [4:0] code, output logic err);
        pulses = 0;
        code   = 5'h00;
        err    = 1'b0;
        for (int k = 0; k < n; k++) begin
            tick();
            if (bus_hi.code_valid === 1'b1) begin
                if (pulses == 0) begin
                    code = bus_hi.code_out;
                    err  = bus_hi.code_err;
                end
                pulses++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n              = 1'b0;
        bus_hi.seg7        = 7'h7F;
        bus_hi.code_ready  = 1'b0;
        bus_hi.overrun_clr = 1'b0;
        bus_lo.seg7        = 7'h7F;
        bus_lo.code_ready  = 1'b0;
        bus_lo.overrun_clr = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (bus_hi.code_out !== 5'h00) begin n_fail++; $display("FAIL reset_code_out got %h want 00", bus_hi.code_out); end
        n_checks++;
        if (bus_hi.code_err !== 1'b0) begin n_fail++; $display("FAIL reset_code_err got %b want 0", bus_hi.code_err); end
        n_checks++;
        if (bus_hi.code_valid !== 1'b0) begin n_fail++; $display("FAIL reset_code_valid got %b want 0", bus_hi.code_valid); end
        n_checks++;
        if (bus_hi.overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b want 0", bus_hi.overrun); end
        rst_n = 1'b1;
        repeat (6) tick();
        n_checks++;
        if (bus_hi.code_valid !== 1'b0) begin n_fail++; $display("FAIL latency_early_valid got %b want 0", bus_hi.code_valid); end
        tick();
        n_checks++;
        if (bus_hi.code_valid !== 1'b1) begin n_fail++; $display("FAIL latency_valid got %b want 1", bus_hi.code_valid); end
        n_checks++;
        if (bus_hi.code_out !== 5'h08) begin n_fail++; $display("FAIL latency_code got %h want 08", bus_hi.code_out); end
        n_checks++;
        if (bus_hi.code_err !== 1'b0) begin n_fail++; $display("FAIL latency_err got %b want 0", bus_hi.code_err); end
        bus_hi.code_ready = 1'b1;
        tick();
        n_checks++;
        if (bus_hi.code_valid !== 1'b0) begin n_fail++; $display("FAIL accept_drop_valid got %b want 0", bus_hi.code_valid); end
    endtask

    task automatic test_sweep();
        logic [6:0] pats [0:16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F,
                                    7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71, 7'h00};
        int         p;
        logic [4:0] c;
        logic       e;
        bus_hi.code_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            bus_hi.seg7 = pats[i];
            run_window(10, p, c, e);
            n_checks++;
            if (p !== 1) begin n_fail++; $display("FAIL sweep_pulses[%0d] got %0d want 1", i, p); end
            n_checks++;
            if (c !== 5'(i)) begin n_fail++; $display("FAIL sweep_code[%0d] got %h want %h", i, c, 5'(i)); end
            n_checks++;
            if (e !== 1'b0) begin n_fail++; $display("FAIL sweep_err[%0d] got %b want 0", i, e); end
        end
    endtask

    task automatic test_glitch();
        int         pa, pb;
        logic [4:0] ca, cb;
        logic       ea, eb;
        bus_hi.code_ready = 1'b1;
        bus_hi.seg7 = 7'h06;
        run_window(10, pa, ca, ea);
        n_checks++;
        if (pa !== 1 || ca !== 5'h01) begin n_fail++; $display("FAIL glitch_base got %0d pulses code %h want 1 pulse code 01", pa, ca); end
        bus_hi.seg7 = 7'h4F;
        run_window(3, pa, ca, ea);
        bus_hi.seg7 = 7'h06;
        run_window(10, pb, cb, eb);
        n_checks++;
        if (pa + pb !== 0) begin n_fail++; $display("FAIL glitch_short got %0d pulses want 0", pa + pb); end
        bus_hi.seg7 = 7'h4F;
        run_window(5, pa, ca, ea);
        bus_hi.seg7 = 7'h06;
        run_window(10, pb, cb, eb);
        n_checks++;
        if (pa + pb !== 2) begin n_fail++; $display("FAIL glitch_long_pulses got %0d want 2", pa + pb); end
        n_checks++;
        if (((pa > 0) ? ca : cb) !== 5'h03) begin n_fail++; $display("FAIL glitch_long_code got %h want 03", (pa > 0) ? ca : cb); end
    endtask

    task automatic test_invalid();
        int         p;
        logic [4:0] c;
        logic       e;
        bus_hi.code_ready = 1'b1;
        bus_hi.seg7 = 7'h01;
        run_window(10, p, c, e);
        n_checks++;
        if (p !== 1 || c !== 5'h1F || e !== 1'b1) begin n_fail++; $display("FAIL invalid_code got %0d pulses code %h err %b want 1 1F 1", p, c, e); end
        bus_hi.seg7 = 7'h3F;
        run_window(10, p, c, e);
        n_checks++;
        if (p !== 1 || c !== 5'h00 || e !== 1'b0) begin n_fail++; $display("FAIL invalid_recover got %0d pulses code %h err %b want 1 00 0", p, c, e); end
    endtask

    task automatic test_backpressure();
        bus_hi.code_ready = 1'b0;
        bus_hi.seg7 = 7'h5B;
        repeat (10) tick();
        n_checks++;
        if (bus_hi.code_valid !== 1'b1 || bus_hi.code_out !== 5'h02 || bus_hi.overrun !== 1'b0) begin
            n_fail++; $display("FAIL bp_first got v%b code %h ovr %b want v1 02 ovr0", bus_hi.code_valid, bus_hi.code_out, bus_hi.overrun);
        end
        bus_hi.seg7 = 7'h66;
        repeat (10) tick();
        n_checks++;
        if (bus_hi.code_out !== 5'h04) begin n_fail++; $display("FAIL bp_overwrite_code got %h want 04", bus_hi.code_out); end
        n_checks++;
        if (bus_hi.overrun !== 1'b1) begin n_fail++; $display("FAIL bp_overrun got %b want 1", bus_hi.overrun); end
        n_checks++;
        if (bus_hi.code_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_held got %b want 1", bus_hi.code_valid); end
        bus_hi.code_ready = 1'b1;
        tick();
        bus_hi.code_ready = 1'b0;
        n_checks++;
        if (bus_hi.code_valid !== 1'b0 || bus_hi.code_out !== 5'h04) begin
            n_fail++; $display("FAIL bp_accept got v%b code %h want v0 04", bus_hi.code_valid, bus_hi.code_out);
        end
        n_checks++;
        if (bus_hi.overrun !== 1'b1) begin n_fail++; $display("FAIL bp_overrun_sticky got %b want 1", bus_hi.overrun); end
        bus_hi.overrun_clr = 1'b1;
        tick();
        bus_hi.overrun_clr = 1'b0;
        n_checks++;
        if (bus_hi.overrun !== 1'b0) begin n_fail++; $display("FAIL bp_overrun_clr got %b want 0", bus_hi.overrun); end
    endtask

    task automatic test_active_low();
        bus_lo.code_ready = 1'b0;
        bus_lo.seg7 = 7'h40;
        repeat (10) tick();
        bus_lo.seg7 = 7'h12;
        repeat (10) tick();
        n_checks++;
        if (bus_lo.code_valid !== 1'b1 || bus_lo.code_out !== 5'h05 || bus_lo.code_err !== 1'b0) begin
            n_fail++; $display("FAIL al_decode got v%b code %h err %b want v1 05 0", bus_lo.code_valid, bus_lo.code_out, bus_lo.code_err);
        end
        n_checks++;
        if (bus_lo.overrun !== 1'b1) begin n_fail++; $display("FAIL al_overrun got %b want 1", bus_lo.overrun); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus_lo.code_valid !== 1'b0 || bus_lo.overrun !== 1'b0 || bus_lo.code_out !== 5'h00) begin
            n_fail++; $display("FAIL al_async_reset got v%b ovr %b code %h want v0 ovr0 00", bus_lo.code_valid, bus_lo.overrun, bus_lo.code_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_sweep();
        test_glitch();
        test_invalid();
        test_backpressure();
        test_active_low();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
